// File: rtl/seq_detector_param_if.sv
// Bus bundle for seq_detector_param: configuration, serial input and match outputs.
//   cfg_we/cfg_pattern/cfg_overlap : runtime pattern and overlap-mode load
//   cnt_clr                        : synchronous clear of match_cnt
//   x_valid/x                      : qualified serial bit
//   z/z_r/match_cnt                : Mealy match pulse, registered copy, saturating count
interface seq_detector_param_if #(
    parameter int unsigned N     = 3,
    parameter int unsigned CNT_W = 8
);
    logic             cfg_we;
    logic [N-1:0]     cfg_pattern;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             x_valid;
    logic             x;
    logic             z;
    logic             z_r;
    logic [CNT_W-1:0] match_cnt;

    // Stream/config source side
    modport master (
        output cfg_we, cfg_pattern, cfg_overlap, cnt_clr, x_valid, x,
        input  z, z_r, match_cnt
    );

    // Detector side
    modport slave (
        input  cfg_we, cfg_pattern, cfg_overlap, cnt_clr, x_valid, x,
        output z, z_r, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable N-bit serial sequence detector with overlap mode and a
// saturating match counter.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : seq_detector_param_if.slave (config, serial bit in, z / z_r / match_cnt out)
module seq_detector_param #(
    parameter int unsigned N               = 3,
    parameter int unsigned CNT_W           = 8,
    parameter logic [N-1:0] RST_PATTERN    = N'(3'b011),
    parameter logic        RST_OVERLAP     = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);
    localparam int unsigned HIST_W = N - 1;
    localparam int unsigned FILL_W = $clog2(N);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [N-1:0]      pattern_q, pattern_d;
    logic              overlap_q, overlap_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              z_r_q, z_r_d;

    logic accept_c;
    logic match_c;

    // A bit is consumed only when valid and not shadowed by a config load;
    // rst gating keeps z low for the whole time reset is held.
    always_comb begin
        accept_c = bus.x_valid & ~bus.cfg_we;
        match_c  = rst & accept_c & (fill_q == FILL_FULL) &
                   ({hist_q, bus.x} == pattern_q);
    end

    // Next-state for pattern/history/fill/counter/registered pulse
    always_comb begin
        pattern_d = pattern_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        z_r_d     = match_c;

        if (bus.cfg_we) begin
            pattern_d = bus.cfg_pattern;
            overlap_d = bus.cfg_overlap;
            fill_d    = '0;
        end else if (accept_c) begin
            hist_d = HIST_W'({hist_q, bus.x});
            if (match_c) begin
                // Overlap keeps the window full so a suffix can start the next match
                fill_d = overlap_q ? FILL_FULL : '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        // Clear wins over a same-cycle match
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (match_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q <= RST_PATTERN;
            overlap_q <= RST_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            z_r_q     <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            z_r_q     <= z_r_d;
        end
    end

    assign bus.z         = match_c;
    assign bus.z_r       = z_r_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (N=3, CNT_W=2 so saturation is reachable).
module tb_seq_detector_param;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seq_detector_param_if #(.N(3), .CNT_W(2)) bus ();

    seq_detector_param #(
        .N          (3),
        .CNT_W      (2),
        .RST_PATTERN(3'b011),
        .RST_OVERLAP(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One cycle of stream input; z checked mid-cycle before the next rising edge
    task automatic drive(input string tag, input logic v, input logic b,
                         input logic clr, input logic ez);
        @(negedge clk);
        bus.cfg_we  = 1'b0;
        bus.x_valid = v;
        bus.x       = b;
        bus.cnt_clr = clr;
        #2;
        check_eq(tag, 32'(bus.z), 32'(ez));
    endtask

    // Idle cycle; checks the registered results of the previous cycle
    task automatic idle_chk(input string tag, input logic ezr, input int ecnt);
        @(negedge clk);
        bus.cfg_we  = 1'b0;
        bus.x_valid = 1'b0;
        bus.cnt_clr = 1'b0;
        #2;
        check_eq({tag, "_zr"}, 32'(bus.z_r), 32'(ezr));
        check_eq({tag, "_cnt"}, 32'(bus.match_cnt), 32'(ecnt));
    endtask

    task automatic cfg_load(input string tag, input logic [2:0] pat, input logic ov,
                            input logic v, input logic b);
        @(negedge clk);
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_overlap = ov;
        bus.x_valid     = v;
        bus.x           = b;
        bus.cnt_clr     = 1'b0;
        #2;
        check_eq(tag, 32'(bus.z), 32'(0));
    endtask

    task automatic clear_cnt();
        @(negedge clk);
        bus.cfg_we  = 1'b0;
        bus.x_valid = 1'b0;
        bus.cnt_clr = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_overlap = 1'b0;
        bus.cnt_clr = 1'b0; bus.x_valid = 1'b0; bus.x = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #2;
        check_eq("rst_z", 32'(bus.z), 32'(0));
        check_eq("rst_zr", 32'(bus.z_r), 32'(0));
        check_eq("rst_cnt", 32'(bus.match_cnt), 32'(0));

        // Reset pattern 011
        drive("def_b0", 1, 0, 0, 0);
        drive("def_b1", 1, 1, 0, 0);
        drive("def_b2", 1, 1, 0, 1);
        idle_chk("def_after", 1, 1);
        clear_cnt();
        idle_chk("def_clr", 0, 0);

        // Gaps are transparent even with x toggling
        drive("gap_b0", 1, 0, 0, 0);
        drive("gap_i0", 0, 1, 0, 0);
        drive("gap_b1", 1, 1, 0, 0);
        drive("gap_i1", 0, 0, 0, 0);
        drive("gap_b2", 1, 1, 0, 1);
        idle_chk("gap_after", 1, 1);
        clear_cnt();

        // Overlap on, pattern 101: 1,0,1,0,1 -> z on bits 3 and 5
        cfg_load("ov1_cfg", 3'b101, 1'b1, 1'b0, 1'b0);
        drive("ov1_b1", 1, 1, 0, 0);
        drive("ov1_b2", 1, 0, 0, 0);
        drive("ov1_b3", 1, 1, 0, 1);
        drive("ov1_b4", 1, 0, 0, 0);
        drive("ov1_b5", 1, 1, 0, 1);
        idle_chk("ov1_after", 1, 2);
        clear_cnt();

        // Overlap off: only bit 3 matches
        cfg_load("ov0_cfg", 3'b101, 1'b0, 1'b0, 1'b0);
        drive("ov0_b1", 1, 1, 0, 0);
        drive("ov0_b2", 1, 0, 0, 0);
        drive("ov0_b3", 1, 1, 0, 1);
        drive("ov0_b4", 1, 0, 0, 0);
        drive("ov0_b5", 1, 1, 0, 0);
        idle_chk("ov0_after", 0, 1);
        clear_cnt();

        // Saturation at 3 with a 2-bit counter
        cfg_load("sat_cfg", 3'b011, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            drive("sat_b0", 1, 0, 0, 0);
            drive("sat_b1", 1, 1, 0, 0);
            drive("sat_b2", 1, 1, 0, 1);
            idle_chk("sat_rep", 1, (k > 3) ? 3 : k);
        end
        // Clear beats a same-cycle match
        drive("satclr_b0", 1, 0, 0, 0);
        drive("satclr_b1", 1, 1, 0, 0);
        drive("satclr_b2", 1, 1, 1, 1);
        idle_chk("satclr_after", 1, 0);

        // Reconfigure mid-stream: old pattern would have matched on the cfg cycle
        drive("rcf_b0", 1, 0, 0, 0);
        drive("rcf_b1", 1, 1, 0, 0);
        cfg_load("rcf_cfg", 3'b110, 1'b0, 1'b1, 1'b1);
        drive("rcf_b2", 1, 1, 0, 0);
        drive("rcf_b3", 1, 1, 0, 0);
        drive("rcf_b4", 1, 0, 0, 1);

        // Async reset while z_r and count are set
        drive("ar_b0", 1, 0, 0, 0);
        check_eq("ar_pre_zr", 32'(bus.z_r), 32'(1));
        check_eq("ar_pre_cnt", 32'(bus.match_cnt), 32'(1));
        drive("ar_b1", 1, 1, 0, 0);
        #1 rst = 1'b0;
        #1;
        check_eq("ar_zr", 32'(bus.z_r), 32'(0));
        check_eq("ar_cnt", 32'(bus.match_cnt), 32'(0));
        check_eq("ar_z", 32'(bus.z), 32'(0));
        @(negedge clk);
        bus.x_valid = 1'b1; bus.x = 1'b1;
        #2;
        check_eq("ar_hold_z", 32'(bus.z), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        #2;
        check_eq("ar_rel_b1", 32'(bus.z), 32'(0));
        drive("ar_b2", 1, 0, 0, 0);
        drive("ar_b3", 1, 1, 0, 0);
        drive("ar_b4", 1, 1, 0, 1);
        idle_chk("ar_after", 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
